// File: rtl/pipelined_block_adder_pkg.sv
// Shared configuration helpers and mode encoding for the pipelined block adder.
package pipelined_block_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bits resolved by one pipeline stage.
  function automatic int slice_w(input int bw, input int bps);
    return bw * bps;
  endfunction

  // Number of register-separated stages.
  function automatic int num_stages(input int w, input int bw, input int bps);
    return w / (bw * bps);
  endfunction

  // A configuration is usable only if the width splits evenly into stage slices.
  function automatic bit legal_cfg(input int w, input int bw, input int bps);
    return (w > 1) && (bw > 0) && (bps > 0) && ((w % (bw * bps)) == 0);
  endfunction

endpackage

// File: rtl/pipelined_block_adder_if.sv
// Streaming request/result bundle for the pipelined block adder.
interface pipelined_block_adder_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_cin;
  logic                 in_sub;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_sum;
  logic                 out_cout;
  logic                 out_ovf;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/pipelined_block_adder_lookahead_block.sv
// Combinational BW-bit carry-lookahead block: internal carries from bit
// propagate/generate, block carry-out from group generate/propagate.
module lookahead_block #(
  parameter int BW = 4
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          cin,
  output logic [BW-1:0] sum,
  output logic          cout
);
  logic [BW-1:0] p;
  logic [BW-1:0] g;
  logic [BW-1:0] c;
  logic          gg;
  logic          gp;

  assign p = a ^ b;
  assign g = a & b;

  // Group generate/propagate over the whole block.
  always_comb begin
    gg = 1'b0;
    gp = 1'b1;
    for (int i = 0; i < BW; i++) begin
      gg = g[i] | (p[i] & gg);
      gp = gp & p[i];
    end
  end

  // Carry into each bit of the block.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 1; i < BW; i++) c[i] = g[i-1] | (p[i-1] & c[i-1]);
  end

  assign sum  = p ^ c;
  assign cout = gg | (gp & cin);
endmodule

// File: rtl/pipelined_block_adder.sv
// Pipelined add/subtract: one slice of S bits resolved per stage, carry and
// unprocessed operand bits travel down the pipe with a valid/ready chain.
module pipelined_block_adder
  import pipelined_block_adder_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int BLOCK_WIDTH      = 4,
  parameter int BLOCKS_PER_STAGE = 2,
  parameter int TAG_WIDTH        = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_block_adder_if.slave bus
);
  localparam int S      = slice_w(BLOCK_WIDTH, BLOCKS_PER_STAGE);
  localparam int STAGES = num_stages(WIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE);
  localparam int LAST   = STAGES - 1;

  if (!legal_cfg(WIDTH, BLOCK_WIDTH, BLOCKS_PER_STAGE)) begin : g_bad_cfg
    $error("pipelined_block_adder: WIDTH must be a multiple of BLOCK_WIDTH*BLOCKS_PER_STAGE");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic                 v_q, v_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic                 c_q, c_d;
    logic [TAG_WIDTH-1:0] t_q, t_d;

    logic                 rdy, rdy_nxt, vin, ld;
    logic [WIDTH-1:0]     a_in, b_in, s_in;
    logic                 c_in;
    logic [TAG_WIDTH-1:0] t_in;
    logic [S-1:0]         sl;
    logic                 bc [BLOCKS_PER_STAGE+1];

    // Stage 0 conditions the raw operands; later stages take the previous registers.
    if (k == 0) begin : g_src
      assign vin  = bus.in_valid;
      assign a_in = bus.in_a;
      assign b_in = (bus.in_sub == MODE_SUB) ? ~bus.in_b   : bus.in_b;
      assign c_in = (bus.in_sub == MODE_SUB) ? ~bus.in_cin : bus.in_cin;
      assign s_in = '0;
      assign t_in = bus.in_tag;
    end else begin : g_src
      assign vin  = g_stg[k-1].v_q;
      assign a_in = g_stg[k-1].a_q;
      assign b_in = g_stg[k-1].b_q;
      assign c_in = g_stg[k-1].c_q;
      assign s_in = g_stg[k-1].s_q;
      assign t_in = g_stg[k-1].t_q;
    end

    if (k == LAST) begin : g_nxt
      assign rdy_nxt = bus.out_ready;
      // Only the sign bits of the operands matter past the last slice.
      logic unused_ops;
      assign unused_ops = ^{a_q[WIDTH-2:0], b_q[WIDTH-2:0]};
    end else begin : g_nxt
      assign rdy_nxt = g_stg[k+1].rdy;
    end

    // An empty stage always loads, so bubbles collapse under backpressure.
    assign rdy = !v_q | rdy_nxt;
    assign ld  = rdy & vin;

    assign bc[0] = c_in;
    for (genvar j = 0; j < BLOCKS_PER_STAGE; j++) begin : g_blk
      lookahead_block #(.BW(BLOCK_WIDTH)) u_blk (
        .a   (a_in[k*S + j*BLOCK_WIDTH +: BLOCK_WIDTH]),
        .b   (b_in[k*S + j*BLOCK_WIDTH +: BLOCK_WIDTH]),
        .cin (bc[j]),
        .sum (sl[j*BLOCK_WIDTH +: BLOCK_WIDTH]),
        .cout(bc[j+1])
      );
    end

    // Next state: splice this stage's slice into the partial result.
    always_comb begin
      v_d          = rdy ? vin : v_q;
      a_d          = a_in;
      b_d          = b_in;
      c_d          = bc[BLOCKS_PER_STAGE];
      t_d          = t_in;
      s_d          = s_in;
      s_d[k*S +: S] = sl;
    end

    // Stage registers; a stalled stage holds everything.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        t_q <= '0;
      end else begin
        v_q <= v_d;
        if (ld) begin
          a_q <= a_d;
          b_q <= b_d;
          s_q <= s_d;
          c_q <= c_d;
          t_q <= t_d;
        end
      end
    end
  end

  assign bus.in_ready  = g_stg[0].rdy;
  assign bus.out_valid = g_stg[LAST].v_q;
  assign bus.out_sum   = g_stg[LAST].s_q;
  assign bus.out_cout  = g_stg[LAST].c_q;
  assign bus.out_tag   = g_stg[LAST].t_q;
  assign bus.out_ovf   = (g_stg[LAST].a_q[WIDTH-1] == g_stg[LAST].b_q[WIDTH-1]) &
                         (g_stg[LAST].s_q[WIDTH-1] != g_stg[LAST].a_q[WIDTH-1]);
endmodule

// File: tb/tb_pipelined_block_adder.sv
// Randomized + directed bench for pipelined_block_adder with a queue-based
// arithmetic reference model.
module tb_pipelined_block_adder;
  localparam int W      = 32;
  localparam int TW     = 4;
  localparam int STAGES = 4;
  localparam longint TWO_W = 64'h1_0000_0000;
  localparam longint MAXS  = 64'sh7FFF_FFFF;
  localparam longint MINS  = -64'sh8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_block_adder_if #(.WIDTH(W), .TAG_WIDTH(TW)) bus();

  pipelined_block_adder #(
    .WIDTH(W), .BLOCK_WIDTH(4), .BLOCKS_PER_STAGE(2), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [TW-1:0] tag;
  } res_t;

  res_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;
  bit   done = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain wide integer arithmetic, unsigned for carry, signed for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input logic [TW-1:0] tag);
    res_t   r;
    longint ua, ub, us, sa, sb, ss, ci;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = cin ? 64'd1 : 64'd0;
    if (!sub) begin
      us = ua + ub + ci;
      ss = sa + sb + ci;
      r.cout = (us >= TWO_W);
    end else begin
      us = ua - ub - ci;
      ss = sa - sb - ci;
      r.cout = (us >= 0);
    end
    r.sum = us[W-1:0];
    r.ovf = (ss > MAXS) || (ss < MINS);
    r.tag = tag;
    return r;
  endfunction

  // Monitor: record accepted ops, score delivered results, check stall stability.
  initial begin
    bit   held;
    res_t hold_v, got, e;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) held = 0;
      else begin
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub, bus.in_tag));
        if (bus.out_valid) begin
          got = {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_tag};
          if (held) chk("stall_stable", got, hold_v);
          if (bus.out_ready) begin
            n_out++;
            held = 0;
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else begin
              e = exp_q.pop_front();
              chk("result", got, e);
            end
          end else begin
            held   = 1;
            hold_v = got;
          end
        end else held = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input logic [TW-1:0] tag);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub; bus.in_tag = tag;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 200) begin
        chk("send_timeout", 0, 1);
        acc = 1;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin cyc(1); n++; end
    chk("drain_empty", exp_q.size(), 0);
    cyc(1);
  endtask

  task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic [TW-1:0] tag,
                         input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    bus.out_ready = 1'b1;
    send(a, b, cin, sub, tag);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin cyc(1); lat++; end
    chk({nm, "_lat"},  lat, STAGES);
    chk({nm, "_sum"},  bus.out_sum, es);
    chk({nm, "_cout"}, bus.out_cout, ec);
    chk({nm, "_ovf"},  bus.out_ovf, eo);
    chk({nm, "_tag"},  bus.out_tag, tag);
    cyc(1);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, n0;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 0; bus.in_sub = 0;
    bus.in_tag = '0; bus.out_ready = 1'b1;

    // Reset state
    cyc(3);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sum",   bus.out_sum, 0);
    chk("rst_cout",  bus.out_cout, 0);
    chk("rst_ovf",   bus.out_ovf, 0);
    chk("rst_tag",   bus.out_tag, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inrdy", bus.in_ready, 1);
    cyc(1);

    // Directed arithmetic
    run_one("add5p3",  32'h5,         32'h3, 0, 0, 4'h3, 32'h8,         0, 0);
    run_one("ripple",  32'hFFFF_FFFF, 32'h0, 1, 0, 4'h5, 32'h0,         1, 0);
    run_one("subovf",  32'h8000_0000, 32'h1, 0, 1, 4'h6, 32'h7FFF_FFFF, 1, 1);
    run_one("sub3m5",  32'h3,         32'h5, 0, 1, 4'h9, 32'hFFFF_FFFE, 0, 0);
    run_one("possovf", 32'h7FFF_FFFF, 32'h0, 1, 0, 4'hA, 32'h8000_0000, 0, 1);

    // Backpressure: 8 ops, output stalled 6 cycles after the first result
    bus.out_ready = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
        bus.in_valid = 1'b0;
      end
      begin
        int m;
        m = 0;
        while (!bus.out_valid && m < 50) begin cyc(1); m++; end
        chk("bp_first_valid", bus.out_valid, 1);
        chk("bp_inrdy_full",  bus.in_ready, 0);
        chk("bp_first_tag",   bus.out_tag, 0);
        cyc(6);
        chk("bp_inrdy_held",  bus.in_ready, 0);
        chk("bp_valid_held",  bus.out_valid, 1);
        chk("bp_tag_held",    bus.out_tag, 0);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - n0, 8);

    // Bubble collapse
    bus.out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 0, 0, 4'h8);
    bus.in_valid = 1'b0;
    repeat (2) begin @(negedge clk); chk("bub_inrdy", bus.in_ready, 1); cyc(1); end
    send(32'h0000_0010, 32'h0000_0001, 0, 1, 4'h9);
    bus.in_valid = 1'b0;
    repeat (6) begin @(negedge clk); chk("bub_inrdy", bus.in_ready, 1); cyc(1); end
    chk("bub_valid", bus.out_valid, 1);
    chk("bub_tag0",  bus.out_tag, 8);
    bus.out_ready = 1'b1;
    @(negedge clk); chk("bub_b2b_v0", bus.out_valid, 1); chk("bub_b2b_t0", bus.out_tag, 8);
    @(negedge clk); chk("bub_b2b_v1", bus.out_valid, 1); chk("bub_b2b_t1", bus.out_tag, 9);
    @(negedge clk); chk("bub_empty",  bus.out_valid, 0);
    cyc(1);

    // Reset mid-stream with 3 ops in flight
    bus.out_ready = 1'b0;
    send(32'h0000_00F0, 32'h0000_000F, 0, 0, 4'h1);
    send(32'h0000_0100, 32'h0000_0001, 0, 0, 4'h2);
    send(32'h0000_0200, 32'h0000_0002, 0, 0, 4'h3);
    bus.in_valid = 1'b0;
    cyc(1);
    chk("mid_pre_valid", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_sum",   bus.out_sum, 0);
    chk("mid_rst_tag",   bus.out_tag, 0);
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_inrdy", bus.in_ready, 1);
    chk("mid_valid", bus.out_valid, 0);
    cyc(1);
    run_one("postrst", 32'hDEAD_BEEF, 32'h0000_0001, 1, 0, 4'hC, 32'hDEAD_BEF1, 0, 0);
    n0 = n_out;
    cyc(8);
    chk("postrst_no_stale", n_out - n0, 0);

    // Randomized stream with random backpressure
    n0 = n_out;
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin bus.in_valid = 1'b0; cyc($urandom_range(1, 2)); end
          send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
        end
        bus.in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          cyc(1);
        end
      end
    join
    drain();
    chk("rand_count", n_out - n0, 300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipelined_block_adder.md
Name: pipelined_block_adder

Overview:
Parametrised, pipelined successor to the combinational block-carry adder. Splits a WIDTH-bit add/subtract into STAGES register-separated slices. Each slice is built from BLOCK_WIDTH-bit carry-lookahead blocks. Uses a valid/ready handshake with full backpressure and carries a sideband tag, so it drops into the datapath between streaming producers and consumers. Adds a subtract mode and signed-overflow detection.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of BLOCK_WIDTH*BLOCKS_PER_STAGE.
BLOCK_WIDTH, 4, bits per carry-lookahead block (group propagate/generate computed per block).
BLOCKS_PER_STAGE, 2, blocks resolved per pipeline stage; STAGES = WIDTH/(BLOCK_WIDTH*BLOCKS_PER_STAGE).
TAG_WIDTH, 4, sideband tag carried alongside each operation.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operation offered.
in_ready  output  1  pipe accepts operation this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in (add) / borrow-in (sub).
in_sub  input  1  0: A+B+cin; 1: A-B-cin.
in_tag  input  TAG_WIDTH  sideband, returned unchanged.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  result.
out_cout  output  1  raw carry out of MSB (sub: 1 = no borrow).
out_ovf  output  1  two's-complement signed overflow.
out_tag  output  TAG_WIDTH  tag of this result.

Behaviour:
- Operand conditioning at input: b_eff = in_sub ? ~in_b : in_b; c_eff = in_sub ? ~in_cin : in_cin. Result = A + b_eff + c_eff, mod 2^WIDTH.
- Stage k (0..STAGES-1) computes sum bits [(k+1)*S-1 : k*S], where S = BLOCK_WIDTH*BLOCKS_PER_STAGE.
  - Stage k uses the carry registered by stage k-1 (stage 0 uses c_eff).
  - Within a stage, each block's carry-out = group generate | (group propagate & block carry-in).
  - Stage k registers: its completed sum slice, stage carry-out, the not-yet-added upper operand bits, lower result bits already computed, sign bits of A and b_eff, and the tag.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, with no stalls. Throughput: 1 op/cycle.
- Per-stage valid bit v[k]. Stage k loads when ready[k] = !v[k] | ready[k+1], with ready[STAGES] = out_ready.
  - in_ready = ready[0], combinational from out_ready through the chain. No combinational path from in_valid to in_ready.
  - Bubbles collapse: an empty stage loads even while downstream is stalled.
  - A stage that holds data and cannot advance keeps all its registers unchanged.
- out_* are driven by the final stage registers. out_sum, out_cout, out_ovf and out_tag stay stable while out_valid=1 and out_ready=0.
- out_ovf = (A[MSB] == b_eff[MSB]) & (sum[MSB] != A[MSB]).
- Reset (asynchronous, any time, including mid-operation):
  - All v[k] clear and all data registers clear to 0, so out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_tag=0.
  - In-flight operations are discarded.
  - in_ready=1 from the first cycle after reset deasserts.
- in_valid=0 inserts a bubble. Operand values are ignored when not accepted.
- Simultaneous accept at input and output while the pipe is full: both transfers occur and occupancy stays constant.

Decomposition:
- Shared package: STAGES/stage-slice-width localparam functions, parameter legality check (elaboration error if WIDTH mod S != 0), and the mode encoding constants ADD=0 / SUB=1.
- One sub-module, lookahead_block: combinational BLOCK_WIDTH-bit adder with inputs a, b, cin and outputs sum, cout. Instantiated BLOCKS_PER_STAGE times per stage.
- Top level holds the stage registers and the handshake chain.

Test Plan:
- Default params, out_ready=1: A=0x0000_0005, B=0x0000_0003, cin=0, add -> after 4 cycles sum=0x0000_0008, cout=0, ovf=0, tag echoed.
- Full carry ripple: A=0xFFFF_FFFF, B=0x0000_0000, cin=1, add -> sum=0x0000_0000, cout=1, ovf=0. Checks the carry crossing every stage register.
- Subtract and overflow:
  - 0x8000_0000 - 0x0000_0001, cin=0 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
  - 0x0000_0003 - 0x0000_0005 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
- Backpressure: stream 8 ops with tags 0..7 and hold out_ready=0 for 6 cycles after the first result.
  - in_ready drops once 4 ops are in flight.
  - Output stays stable while stalled.
  - On release, all 8 results emerge in order, with no loss or duplication.
- Bubble collapse: issue op, 2 idle cycles, op, with out_ready=0 -> both ops end up in the last two stages and in_ready=1 throughout. On release, outputs appear back-to-back.
- Reset mid-stream with 3 ops in flight -> out_valid=0 and out_sum=0 immediately (asynchronous). After release, a new op returns a correct result after 4 cycles, and no stale result appears.
